// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - fetch stage: ROM addressing, instruction register, jump/branch/halt resolution
// Squashes the single wrong-path fetch that follows a taken redirect.
module instr_fetch_stage #(
  parameter int          N         = 8,
  parameter int          W         = 16,
  parameter int unsigned RESET_VEC = 0
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic [N-1:0] PC_in,
  input  logic         Zero_flag,
  output logic [N-1:0] Mem_addr,
  input  logic [W-1:0] Mem_rdata,
  output logic         Load_en,
  output logic [N-1:0] Data_out,
  output logic [W-1:0] Instr,
  output logic [N-1:0] Instr_pc,
  output logic         Instr_valid,
  output logic         Halted
);

  localparam logic [3:0]   OP_JMP  = 4'hA;
  localparam logic [3:0]   OP_BZ   = 4'hB;
  localparam logic [3:0]   OP_HALT = 4'hF;
  localparam logic [N-1:0] RST_PC  = N'(RESET_VEC);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_pc_q;
  logic           a_v_q, a_v_d;
  logic [N-1:0]   halt_pc_q, halt_pc_d;
  logic [W-1:0]   instr_q;
  logic [N-1:0]   instr_pc_q;
  logic           instr_valid_q;

  logic [3:0]     opcode;
  logic           redirect;
  logic [N-1:0]   target;

  assign Mem_addr = PC_in;
  assign opcode   = Mem_rdata[W-1:W-4];

  always_comb begin
    redirect  = 1'b0;
    target    = Mem_rdata[N-1:0];
    state_d   = state_q;
    halt_pc_d = halt_pc_q;
    if (a_v_q) begin
      unique case (opcode)
        OP_JMP:  redirect = 1'b1;
        OP_BZ:   redirect = Zero_flag;
        OP_HALT: begin
          redirect  = 1'b1;
          target    = a_pc_q;
          state_d   = S_HALT;
          halt_pc_d = a_pc_q;
        end
        default: redirect = 1'b0;
      endcase
    end
    a_v_d = !Reset && !redirect && (state_q == S_RUN);
  end

  // Reset outranks HALT, which outranks a redirect decoded this cycle.
  always_comb begin
    Load_en  = Reset | redirect | (state_q == S_HALT);
    Data_out = '0;
    if (Reset)                   Data_out = RST_PC;
    else if (state_q == S_HALT)  Data_out = halt_pc_q;
    else if (redirect)           Data_out = target;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= S_RUN;
      a_pc_q        <= '0;
      a_v_q         <= 1'b0;
      halt_pc_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_pc_q        <= PC_in;
      a_v_q         <= a_v_d;
      halt_pc_q     <= halt_pc_d;
      instr_valid_q <= a_v_q;
      if (a_v_q) begin
        instr_q    <= Mem_rdata;
        instr_pc_q <= a_pc_q;
      end
    end
  end

  assign Instr       = instr_q;
  assign Instr_pc    = instr_pc_q;
  assign Instr_valid = instr_valid_q;
  assign Halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - scoreboard bench for instr_fetch_stage with counter, ROM and ISA-level model
module tb_instr_fetch_stage;
  localparam logic [7:0] RV = 8'h00;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  PC_in, Mem_addr, Data_out, Instr_pc;
  logic        Zero_flag, Load_en, Instr_valid, Halted;
  logic [15:0] Mem_rdata, Instr;

  instr_fetch_stage #(.N(8), .W(16), .RESET_VEC(0)) dut (
    .CLK(CLK), .Reset(Reset), .PC_in(PC_in), .Zero_flag(Zero_flag),
    .Mem_addr(Mem_addr), .Mem_rdata(Mem_rdata), .Load_en(Load_en),
    .Data_out(Data_out), .Instr(Instr), .Instr_pc(Instr_pc),
    .Instr_valid(Instr_valid), .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  // Environment: loadable counter and synchronous ROM
  logic [15:0] rom [256];
  logic        zf  [256];
  logic [7:0]  pc_q = 8'h00, raddr_q = 8'h00;
  logic [15:0] rdata_q = 16'h0000;
  always_ff @(posedge CLK) begin
    pc_q    <= Load_en ? Data_out : pc_q + 8'd1;
    raddr_q <= Mem_addr;
    rdata_q <= rom[Mem_addr];
  end
  assign PC_in     = pc_q;
  assign Mem_rdata = rdata_q;
  assign Zero_flag = zf[raddr_q];

  int cyc = 0;
  always_ff @(posedge CLK) cyc <= Reset ? 0 : cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  pc;
    logic [15:0] ins;
  } emit_t;
  emit_t       sbq[$];
  logic        exp_ld [512];
  logic [7:0]  exp_do [512];
  int          halt_cyc;
  int          ncyc_cur = 0;
  bit          sb_en = 1'b0;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction-level execution; timing comes from one slot per instruction plus one bubble per taken redirect.
  task automatic build_model(input int ncyc);
    logic [7:0]  pc;
    logic [15:0] ins;
    int          t;
    bit          taken;
    emit_t       e;
    pc = RV;
    t = 2;
    halt_cyc = 1 << 30;
    for (int c = 0; c <= ncyc; c++) begin
      exp_ld[c] = 1'b0;
      exp_do[c] = 8'h00;
    end
    while (t <= ncyc) begin
      ins = rom[pc];
      if (t < ncyc) begin
        e.cyc = t; e.pc = pc; e.ins = ins;
        sbq.push_back(e);
      end
      if (ins[15:12] == 4'hF) begin
        halt_cyc = t;
        for (int c = t - 1; c <= ncyc; c++) begin
          exp_ld[c] = 1'b1;
          exp_do[c] = pc;
        end
        break;
      end
      taken = (ins[15:12] == 4'hA) || (ins[15:12] == 4'hB && zf[pc]);
      if (taken) begin
        exp_ld[t-1] = 1'b1;
        exp_do[t-1] = ins[7:0];
        pc = ins[7:0];
        t += 2;
      end else begin
        pc = pc + 8'd1;
        t += 1;
      end
    end
  endtask

  always @(negedge CLK) begin : monitor
    emit_t e;
    bit    ev;
    if (sb_en && !Reset && cyc < ncyc_cur) begin
      ev = (sbq.size() > 0) && (sbq[0].cyc == cyc);
      chk("mem_addr", 32'(Mem_addr), 32'(PC_in));
      chk("load_en", 32'(Load_en), 32'(exp_ld[cyc]));
      chk("data_out", 32'(Data_out), 32'(exp_do[cyc]));
      chk("halted", 32'(Halted), 32'(cyc >= halt_cyc));
      chk("instr_valid", 32'(Instr_valid), 32'(ev));
      if (Instr_valid && ev) begin
        e = sbq.pop_front();
        chk("instr", 32'(Instr), 32'(e.ins));
        chk("instr_pc", 32'(Instr_pc), 32'(e.pc));
      end
    end
  end

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) begin
      rom[a] = {8'h10, 8'(a)};
      zf[a]  = 1'b0;
    end
  endtask

  task automatic run_prog(input int ncyc);
    sb_en = 1'b0;
    Reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_load_en", 32'(Load_en), 32'd1);
    chk("rst_data_out", 32'(Data_out), 32'(RV));
    chk("rst_valid", 32'(Instr_valid), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_instr", 32'(Instr), 32'd0);
    chk("rst_instr_pc", 32'(Instr_pc), 32'd0);
    build_model(ncyc);
    ncyc_cur = ncyc;
    sb_en = 1'b1;
    Reset = 1'b0;
    repeat (ncyc) @(posedge CLK);
    #1;
    sb_en = 1'b0;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    sbq.delete();
    Reset = 1'b1;
  endtask

  initial begin
    clear_rom();
    for (int a = 0; a < 4; a++) rom[a] = 16'h1000 + 16'(a);
    run_prog(10);

    clear_rom();
    rom[0] = 16'hA020; rom[8'h20] = 16'h1234;
    run_prog(10);

    clear_rom();
    rom[0] = 16'hB040;
    run_prog(8);
    zf[0] = 1'b1;
    run_prog(8);

    clear_rom();
    rom[3] = 16'hF000;
    run_prog(30);

    clear_rom();
    rom[0] = 16'hA0FE; rom[8'hFE] = 16'h1111; rom[8'hFF] = 16'h2222;
    run_prog(12);

    // Reset asserted in the JMP decode cycle must win over the jump target.
    clear_rom();
    rom[0] = 16'hA020; rom[8'h20] = 16'h1234;
    Reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;
    @(posedge CLK);
    #1 Reset = 1'b1;
    #2;
    chk("rvj_load_en", 32'(Load_en), 32'd1);
    chk("rvj_data_out", 32'(Data_out), 32'(RV));
    @(posedge CLK);
    #1;
    chk("rvj_valid", 32'(Instr_valid), 32'd0);
    chk("rvj_pc", 32'(PC_in), 32'(RV));
    @(posedge CLK);
    #1;
    chk("rvj_no_target_fetch", 32'(Mem_addr == 8'h20), 32'd0);

    for (int n = 0; n < 8; n++) begin
      for (int a = 0; a < 256; a++) begin
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 99);
        if (r < 10)      op = 4'hA;
        else if (r < 22) op = 4'hB;
        else if (r < 24) op = 4'hF;
        else begin
          op = 4'($urandom_range(0, 12));
          if (op >= 4'hA) op = op + 4'd1;
          if (op == 4'hB) op = 4'hC;
        end
        rom[a] = {op, 4'($urandom), 8'($urandom)};
        zf[a]  = 1'($urandom);
      end
      run_prog(200);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
